// File: rtl/time_set_editor.sv
// time_set_editor: push-button command source for the HH:MM:SS digit chain.
// Debounces three buttons, sequences IDLE/EDIT/RUN/HOLD, edits one digit at a
// time with per-digit wrap limits and drives a blink flag for the edited digit.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | after reset, chain held in reset (state bus 0)
//   EDIT   | chain loading setBits (state bus 1), one digit selected
//   RUN    | chain counting (state bus 3), buttons other than mode ignored
//   HOLD   | one-cycle reset command so the chain never sees start->set
module time_set_editor #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_MAX        = 49999999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_next,
  input  logic        btn_inc,
  input  logic [23:0] currentBits,
  output logic [3:0]  state,
  output logic [23:0] setBits,
  output logic [2:0]  selDigit,
  output logic        blink
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TK_W = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_PRE  = DB_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_MAX);
  localparam logic [TK_W-1:0] TK_HALF = TK_W'(TICK_MAX / 2);

  typedef enum logic [1:0] {S_IDLE, S_EDIT, S_RUN, S_HOLD} fsm_t;

  logic [2:0] w_btn_raw;
  logic [2:0] w_rise;
  logic       w_mode;
  logic       w_next;
  logic       w_inc;

  assign w_btn_raw = {btn_inc, btn_next, btn_mode};

  // Per-button synchronizer, debouncer and rising-edge pulse generator.
  // The sample that first shows a new level counts as the first stable one,
  // so the debounced level follows DEBOUNCE_CYCLES identical samples.
  for (genvar g = 0; g < 3; g++) begin : g_db
    logic            r_s0;
    logic            r_s1;
    logic            r_last;
    logic            r_lvl;
    logic            r_lvl_d;
    logic [DB_W-1:0] r_cnt;

    // Synchronize, count stable samples, accept level, delay for edge detect.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_s0    <= 1'b0;
        r_s1    <= 1'b0;
        r_last  <= 1'b0;
        r_lvl   <= 1'b0;
        r_lvl_d <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_s0    <= w_btn_raw[g];
        r_s1    <= r_s0;
        r_last  <= r_s1;
        r_lvl_d <= r_lvl;
        if (r_s1 != r_last) begin
          r_cnt <= '0;
        end else begin
          if (r_cnt != DB_LAST) r_cnt <= r_cnt + DB_W'(1);
          if (r_cnt == DB_PRE || r_cnt == DB_LAST) r_lvl <= r_last;
        end
      end
    end

    assign w_rise[g] = r_lvl & ~r_lvl_d;
  end

  // Same-cycle pulses resolve mode > next > inc; losers are dropped.
  assign w_mode = w_rise[0];
  assign w_next = w_rise[1] & ~w_rise[0];
  assign w_inc  = w_rise[2] & ~w_rise[1] & ~w_rise[0];

  fsm_t            r_fsm;
  fsm_t            w_fsm_nxt;
  logic [3:0]      r_state;
  logic [23:0]     r_set;
  logic [2:0]      r_sel;
  logic            r_blink;
  logic [TK_W-1:0] r_tick;

  logic [3:0]      w_state_nxt;
  logic [23:0]     w_set_nxt;
  logic [2:0]      w_sel_nxt;
  logic            w_blink_nxt;
  logic [TK_W-1:0] w_tick_nxt;
  logic [3:0]      w_hhb_inc;
  logic [3:0]      w_lhb_max;

  function automatic logic [3:0] inc_wrap(input logic [3:0] v, input logic [3:0] vmax);
    inc_wrap = (v >= vmax) ? 4'd0 : v + 4'd1;
  endfunction

  assign w_hhb_inc = inc_wrap(r_set[23:20], 4'd2);
  assign w_lhb_max = (r_set[23:20] < 4'd2) ? 4'd9 : 4'd3;

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm   <= S_IDLE;
      r_state <= 4'd0;
      r_set   <= 24'd0;
      r_sel   <= 3'd0;
      r_blink <= 1'b0;
      r_tick  <= '0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_state <= w_state_nxt;
      r_set   <= w_set_nxt;
      r_sel   <= w_sel_nxt;
      r_blink <= w_blink_nxt;
      r_tick  <= w_tick_nxt;
    end
  end

  // Next-state logic: mode pulses walk the cycle, HOLD always lasts one cycle.
  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      S_IDLE: if (w_mode) w_fsm_nxt = S_EDIT;
      S_EDIT: if (w_mode) w_fsm_nxt = S_RUN;
      S_RUN:  if (w_mode) w_fsm_nxt = S_HOLD;
      S_HOLD: w_fsm_nxt = S_EDIT;
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values for the state bus, digits, selection and blink.
  always_comb begin
    w_set_nxt   = r_set;
    w_sel_nxt   = r_sel;
    w_tick_nxt  = '0;
    w_blink_nxt = 1'b0;
    case (w_fsm_nxt)
      S_EDIT:  w_state_nxt = 4'd1;
      S_RUN:   w_state_nxt = 4'd3;
      default: w_state_nxt = 4'd0;
    endcase
    case (r_fsm)
      S_IDLE: begin
        if (w_mode) begin
          w_set_nxt   = 24'd0;
          w_sel_nxt   = 3'd6;
          w_blink_nxt = 1'b1;
        end
      end
      S_EDIT: begin
        if (w_mode) begin
          w_sel_nxt = 3'd0;
        end else if (w_next) begin
          w_sel_nxt   = (r_sel <= 3'd1) ? 3'd6 : r_sel - 3'd1;
          w_blink_nxt = 1'b1;
        end else if (w_inc) begin
          w_blink_nxt = 1'b1;
          case (r_sel)
            3'd1: w_set_nxt[3:0]   = inc_wrap(r_set[3:0], 4'd9);
            3'd2: w_set_nxt[7:4]   = inc_wrap(r_set[7:4], 4'd5);
            3'd3: w_set_nxt[11:8]  = inc_wrap(r_set[11:8], 4'd9);
            3'd4: w_set_nxt[15:12] = inc_wrap(r_set[15:12], 4'd5);
            3'd5: w_set_nxt[19:16] = inc_wrap(r_set[19:16], w_lhb_max);
            3'd6: begin
              w_set_nxt[23:20] = w_hhb_inc;
              if (w_hhb_inc == 4'd2 && r_set[19:16] > 4'd3) w_set_nxt[19:16] = 4'd0;
            end
            default: w_set_nxt = r_set;
          endcase
        end else if (r_tick == TK_LAST) begin
          w_tick_nxt  = '0;
          w_blink_nxt = ~r_blink;
        end else begin
          w_tick_nxt  = r_tick + TK_W'(1);
          w_blink_nxt = (r_tick == TK_HALF) ? ~r_blink : r_blink;
        end
      end
      S_RUN: begin
        if (w_mode) w_set_nxt = currentBits;
      end
      S_HOLD: begin
        w_sel_nxt   = 3'd6;
        w_blink_nxt = 1'b1;
      end
      default: w_sel_nxt = 3'd0;
    endcase
  end

  assign state    = r_state;
  assign setBits  = r_set;
  assign selDigit = r_sel;
  assign blink    = r_blink;

endmodule
